// File: rtl/dict_load_sequencer.sv
// dict_load_sequencer: streams the column-major dictionary RAM into the processor's phi array
module dict_load_sequencer #(
  parameter int SIGNAL_SIZE      = 64,
  parameter int DICTIONARY_SIZE  = 256,
  parameter int ADDR_WIDTH       = 14,
  parameter int DATA_WIDTH       = 32,
  parameter int RAM_READ_LATENCY = 1,
  parameter int STALL_LIMIT      = 4096
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic                               abort_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic                               rd_en_o,
  output logic [ADDR_WIDTH-1:0]              rd_addr_o,
  input  logic [DATA_WIDTH-1:0]              rd_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_WIDTH-1:0]              out_data_o,
  output logic [$clog2(SIGNAL_SIZE)-1:0]     out_row_o,
  output logic [$clog2(DICTIONARY_SIZE)-1:0] out_col_o
);
  localparam int L     = RAM_READ_LATENCY;
  localparam int DEPTH = L + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int SW    = $clog2(STALL_LIMIT + 1);
  localparam int RW    = $clog2(SIGNAL_SIZE);
  localparam int KW    = $clog2(DICTIONARY_SIZE);
  localparam logic [ADDR_WIDTH:0] MN = (ADDR_WIDTH + 1)'(SIGNAL_SIZE * DICTIONARY_SIZE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q;
  logic                  busy_q, done_q, error_q;
  logic [ADDR_WIDTH:0]   addr_q, acc_q;
  logic [CW-1:0]         cnt_q, fcnt_q;
  logic [PW-1:0]         wp_q, rp_q, wp_d, rp_d;
  logic [L-1:0]          pipe_q;
  logic [SW-1:0]         stall_q;
  logic [RW-1:0]         row_q, row_d;
  logic [KW-1:0]         col_q, col_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  pop, push, issue, stalled, stall_hit, last_acc, active;

  // Read credit, FIFO handshake and output view; cnt_q counts reads issued but not yet accepted
  always_comb begin
    out_valid_o = fcnt_q != '0;
    pop         = out_valid_o && out_ready_i;
    stalled     = out_valid_o && !out_ready_i;
    push        = pipe_q[L-1];
    issue       = state_q == RUN && addr_q != MN && (cnt_q < CW'(DEPTH) || pop);
    stall_hit   = stalled && stall_q == SW'(STALL_LIMIT - 1);
    last_acc    = pop && acc_q == MN - 1'b1;
    active      = state_q == RUN || state_q == DRAIN;
    wp_d        = wp_q == PW'(DEPTH - 1) ? '0 : wp_q + PW'(1);
    rp_d        = rp_q == PW'(DEPTH - 1) ? '0 : rp_q + PW'(1);
    row_d       = row_q == RW'(SIGNAL_SIZE - 1) ? '0 : row_q + RW'(1);
    col_d       = row_q == RW'(SIGNAL_SIZE - 1) ? col_q + KW'(1) : col_q;
    rd_en_o     = issue;
    rd_addr_o   = addr_q[ADDR_WIDTH-1:0];
    out_data_o  = out_valid_o ? mem_q[rp_q] : '0;
    out_row_o   = row_q;
    out_col_o   = col_q;
    busy_o      = busy_q;
    done_o      = done_q;
    error_o     = error_q;
  end

  // Sequencer FSM with read pipeline tracking, return FIFO and stall watchdog
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      pipe_q  <= '0;
      stall_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      pipe_q  <= (pipe_q << 1) | L'(issue);
      cnt_q   <= cnt_q + CW'(issue) - CW'(pop);
      fcnt_q  <= fcnt_q + CW'(push) - CW'(pop);
      stall_q <= stalled ? stall_q + SW'(1) : '0;
      if (issue) addr_q <= addr_q + 1'b1;
      if (push) begin
        mem_q[wp_q] <= rd_data_i;
        wp_q        <= wp_d;
      end
      if (pop) begin
        rp_q  <= rp_d;
        acc_q <= acc_q + 1'b1;
        row_q <= row_d;
        col_q <= col_d;
      end
      case (state_q)
        IDLE: if (start_i && !abort_i) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          error_q <= 1'b0;
          addr_q  <= '0;
          acc_q   <= '0;
          row_q   <= '0;
          col_q   <= '0;
        end
        RUN:     if (issue && addr_q == MN - 1'b1) state_q <= DRAIN;
        DONE:    state_q <= IDLE;
        default: ;
      endcase
      if (active && (abort_i || stall_hit)) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        error_q <= error_q || stall_hit;
        cnt_q   <= '0;
        fcnt_q  <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
        pipe_q  <= '0;
        stall_q <= '0;
      end else if (active && last_acc) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end
endmodule
